ham_pair_sequencer: RTL and testbench
=====================================

Name: ham_pair_sequencer

Overview:
Hardware sequencer for the program-1 workload: min/max Hamming distance over all pairs of 16-bit operands.
- Walks every pair (j,k), j<k, of NUM_WORDS operands stored as byte pairs in data memory.
- Computes each pair's Hamming distance and tracks the running min and max with the locations of the winning pairs.
- Writes both results back to data memory, then asserts done.
- Owns the data-memory port while running and drops into the design in place of the software loop.

Parameters:
NUM_WORDS, 32, number of 16-bit operands; operand i = {mem[BASE_ADDR+2i], mem[BASE_ADDR+2i+1]}
BASE_ADDR, 0, byte address of operand 0
MIN_ADDR, 64, byte address receiving the final minimum distance
MAX_ADDR, 65, byte address receiving the final maximum distance
AW, 8, data-memory address width
IW, $clog2(NUM_WORDS), operand index width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; high = hold/abort, low = run (acts as start)
dm_addr  output  AW  data-memory byte address
dm_rd_data  input  8  data-memory read data, combinational from dm_addr (same cycle)
dm_wr_en  output  1  data-memory write strobe, write on rising edge
dm_wr_data  output  8  data-memory write data, zero-extended distance
done  output  1  run complete; high until next reset
min_dist  output  5  running/final minimum Hamming distance
max_dist  output  5  running/final maximum Hamming distance
min_idx_a, min_idx_b  output  IW  lower (j) and higher (k) operand index of min pair
max_idx_a, max_idx_b  output  IW  lower (j) and higher (k) operand index of max pair

Behaviour:
- Reset values (any edge with reset=1):
  - state=IDLE; dm_addr=0; dm_wr_en=0; dm_wr_data=0; done=0.
  - min_dist=16, max_dist=0, all idx=0, j=0, k=1, word registers=0.
- Reset mid-run: aborts on that edge. No write is issued in the cycle reset is high. Restart is fully from scratch.
- States and transitions:
  - IDLE: move to LDJ_HI on the first edge with reset=0.
  - LDJ_HI: dm_addr=BASE+2j; latch wj[15:8].
  - LDJ_LO: dm_addr=BASE+2j+1; latch wj[7:0]; go to LDK_HI.
  - LDK_HI: dm_addr=BASE+2k; latch wk[15:8].
  - LDK_LO: dm_addr=BASE+2k+1; latch wk[7:0].
  - CMP: d = popcount(wj ^ wk), 5-bit, range 0..16.
    - If d < min_dist: min_dist=d, min_idx_a=j, min_idx_b=k.
    - If d > max_dist: max_dist=d, max_idx_a=j, max_idx_b=k.
    - Both updates may occur in the same cycle.
    - Ties keep the earlier pair in scan order (strict compare).
    - Next state: if k<NUM_WORDS-1, then k++ and go to LDK_HI.
    - Else if j<NUM_WORDS-2, then j++, k=j+2 (new j + 1), and go to LDJ_HI.
    - Else go to WR_MIN.
  - WR_MIN: dm_wr_en=1, dm_addr=MIN_ADDR, dm_wr_data={3'b0,min_dist}.
  - WR_MAX: dm_wr_en=1, dm_addr=MAX_ADDR, dm_wr_data={3'b0,max_dist}.
  - DONE: done=1, dm_wr_en=0, dm_addr=0. Holds until reset.
- dm_wr_en is high only in WR_MIN and WR_MAX: exactly two write cycles per completed run. Loads never write.
- Latency: state reaches DONE on edge 1 + 2(N-1) + 3N(N-1)/2 + 2 after the first reset-low edge. For N=32 this is edge 1553; done is a registered state decode.
- All loop counters are IW+1 bits wide so no wrap occurs at k = NUM_WORDS-1.
- No back-to-back run without reset.

Decomposition:
- Package ham_seq_pkg:
  - state_t enum (IDLE, LDJ_HI, LDJ_LO, LDK_HI, LDK_LO, CMP, WR_MIN, WR_MAX, DONE).
  - HAM_MAX=16 and distance width DW=5.
- Sub-module ham16: combinational 16-bit XOR + popcount, output 5 bits. Reused by the bench golden model.

Test Plan:
1. All 32 operands 0xA5A5 -> min_dist=0 at (0,1); max_dist=0 with max idx (0,0); mem[64]=0, mem[65]=0; done on edge 1553.
2. Op0=0x0000, op1=0xFFFF, rest 0x0000 -> max_dist=16 at (0,1); min_dist=0 at (0,2); mem[65]=16.
3. Op i = 1<<(i%16) -> min_dist=0 at (0,16); max_dist=2 at (0,1); exactly two dm_wr_en pulses, at addresses 64 then 65.
4. Ten random data sets (test0..test9 style) -> mem[64] and mem[65] plus all four indices match the ham16-based golden model.
5. Reset raised for one cycle at edge 700 of a run -> no writes, done=0, outputs return to reset values; the rerun completes at edge 1553 with correct results.
6. After done, hold reset low for 100 cycles -> done stays 1, dm_wr_en stays 0, mem[64]/mem[65] unchanged.

Source files
------------

// File: rtl/ham_seq_pkg.sv
// Shared types and constants for the pairwise Hamming min/max sequencer.
package ham_seq_pkg;

  localparam int unsigned HAM_MAX = 16;
  localparam int unsigned DW      = 5;

  typedef enum logic [3:0] {
    IDLE,
    LDJ_HI,
    LDJ_LO,
    LDK_HI,
    LDK_LO,
    CMP,
    WR_MIN,
    WR_MAX,
    DONE
  } state_t;

endpackage

// File: rtl/ham_pair_sequencer_ham16.sv
// Combinational Hamming distance between two 16-bit words (0..16).
module ham16
  import ham_seq_pkg::*;
(
  input  logic [15:0]   a_i,
  input  logic [15:0]   b_i,
  output logic [DW-1:0] dist_c_o
);

  logic [15:0] diff;

  assign diff = a_i ^ b_i;

  // Population count of the differing bits.
  always_comb begin
    dist_c_o = '0;
    for (int i = 0; i < 16; i++) begin
      dist_c_o = dist_c_o + DW'(diff[i]);
    end
  end

endmodule

// File: rtl/ham_pair_sequencer.sv
// Walks all operand pairs in data memory, tracks min/max Hamming distance
// and the pairs that produced them, then writes both results back.
module ham_pair_sequencer
  import ham_seq_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MIN_ADDR  = 64,
  parameter int unsigned MAX_ADDR  = 65,
  parameter int unsigned AW        = 8,
  parameter int unsigned IW        = $clog2(NUM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] dm_addr,
  input  logic [7:0]    dm_rd_data,
  output logic          dm_wr_en,
  output logic [7:0]    dm_wr_data,
  output logic          done,
  output logic [DW-1:0] min_dist,
  output logic [DW-1:0] max_dist,
  output logic [IW-1:0] min_idx_a,
  output logic [IW-1:0] min_idx_b,
  output logic [IW-1:0] max_idx_a,
  output logic [IW-1:0] max_idx_b
);

  // One extra bit on the loop counters so k = NUM_WORDS-1 never wraps.
  localparam int unsigned CW     = IW + 1;
  localparam int unsigned LAST_K = NUM_WORDS - 1;
  localparam int unsigned LAST_J = NUM_WORDS - 2;

  state_t          state_q, state_d;
  logic [CW-1:0]   j_q, j_d, k_q, k_d;
  logic [15:0]     wj_q, wj_d, wk_q, wk_d;
  logic [DW-1:0]   min_q, min_d, max_q, max_d;
  logic [IW-1:0]   mina_q, mina_d, minb_q, minb_d;
  logic [IW-1:0]   maxa_q, maxa_d, maxb_q, maxb_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            done_q, done_d;
  logic [DW-1:0]   dist_c;

  ham16 u_ham16 (
    .a_i      (wj_q),
    .b_i      (wk_q),
    .dist_c_o (dist_c)
  );

  // Next state, loop counters, operand latching, and registered bus decode.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    k_d       = k_q;
    wj_d      = wj_q;
    wk_d      = wk_q;
    min_d     = min_q;
    max_d     = max_q;
    mina_d    = mina_q;
    minb_d    = minb_q;
    maxa_d    = maxa_q;
    maxb_d    = maxb_q;
    addr_d    = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE:   state_d = LDJ_HI;
      LDJ_HI: begin
        wj_d[15:8] = dm_rd_data;
        state_d    = LDJ_LO;
      end
      LDJ_LO: begin
        wj_d[7:0] = dm_rd_data;
        state_d   = LDK_HI;
      end
      LDK_HI: begin
        wk_d[15:8] = dm_rd_data;
        state_d    = LDK_LO;
      end
      LDK_LO: begin
        wk_d[7:0] = dm_rd_data;
        state_d   = CMP;
      end
      CMP: begin
        // Strict compares: ties keep the earlier pair in scan order.
        if (dist_c < min_q) begin
          min_d  = dist_c;
          mina_d = j_q[IW-1:0];
          minb_d = k_q[IW-1:0];
        end
        if (dist_c > max_q) begin
          max_d  = dist_c;
          maxa_d = j_q[IW-1:0];
          maxb_d = k_q[IW-1:0];
        end
        if (k_q < CW'(LAST_K)) begin
          k_d     = k_q + CW'(1);
          state_d = LDK_HI;
        end else if (j_q < CW'(LAST_J)) begin
          j_d     = j_q + CW'(1);
          k_d     = j_q + CW'(2);
          state_d = LDJ_HI;
        end else begin
          state_d = WR_MIN;
        end
      end
      WR_MIN:  state_d = WR_MAX;
      WR_MAX:  state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Address/strobe are registered, so they are decoded from the next state.
    unique case (state_d)
      LDJ_HI: addr_d = AW'(BASE_ADDR) + AW'({j_d, 1'b0});
      LDJ_LO: addr_d = AW'(BASE_ADDR) + AW'({j_d, 1'b1});
      LDK_HI: addr_d = AW'(BASE_ADDR) + AW'({k_d, 1'b0});
      LDK_LO: addr_d = AW'(BASE_ADDR) + AW'({k_d, 1'b1});
      WR_MIN: begin
        addr_d    = AW'(MIN_ADDR);
        wr_en_d   = 1'b1;
        wr_data_d = 8'(min_d);
      end
      WR_MAX: begin
        addr_d    = AW'(MAX_ADDR);
        wr_en_d   = 1'b1;
        wr_data_d = 8'(max_d);
      end
      DONE:    done_d = 1'b1;
      default: addr_d = '0;
    endcase
  end

  // State and datapath registers with synchronous abort/restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      j_q       <= '0;
      k_q       <= CW'(1);
      wj_q      <= '0;
      wk_q      <= '0;
      min_q     <= DW'(HAM_MAX);
      max_q     <= '0;
      mina_q    <= '0;
      minb_q    <= '0;
      maxa_q    <= '0;
      maxb_q    <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      k_q       <= k_d;
      wj_q      <= wj_d;
      wk_q      <= wk_d;
      min_q     <= min_d;
      max_q     <= max_d;
      mina_q    <= mina_d;
      minb_q    <= minb_d;
      maxa_q    <= maxa_d;
      maxb_q    <= maxb_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign dm_addr    = addr_q;
  assign dm_wr_en   = wr_en_q;
  assign dm_wr_data = wr_data_q;
  assign done       = done_q;
  assign min_dist   = min_q;
  assign max_dist   = max_q;
  assign min_idx_a  = mina_q;
  assign min_idx_b  = minb_q;
  assign max_idx_a  = maxa_q;
  assign max_idx_b  = maxb_q;

endmodule

// File: tb/tb_ham_pair_sequencer.sv
// Directed/table-driven bench for ham_pair_sequencer with a behavioural memory.
module tb_ham_pair_sequencer;
  import ham_seq_pkg::*;

  localparam int N   = 32;
  localparam int LAT = 1 + 2 * (N - 1) + 3 * N * (N - 1) / 2 + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dm_addr;
  logic [7:0] dm_rd_data;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;
  logic       done;
  logic [4:0] min_dist, max_dist;
  logic [4:0] min_idx_a, min_idx_b, max_idx_a, max_idx_b;

  always #5 clk = ~clk;

  ham_pair_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .dm_addr    (dm_addr),
    .dm_rd_data (dm_rd_data),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_data (dm_wr_data),
    .done       (done),
    .min_dist   (min_dist),
    .max_dist   (max_dist),
    .min_idx_a  (min_idx_a),
    .min_idx_b  (min_idx_b),
    .max_idx_a  (max_idx_a),
    .max_idx_b  (max_idx_b)
  );

  // Operand bytes (owned by the stimulus) and result capture (owned by the bus).
  logic [7:0]  op_mem [64];
  logic [15:0] words [N];
  assign dm_rd_data = (dm_addr < 8'd64) ? op_mem[dm_addr[5:0]] : 8'h00;

  int         wr_cnt = 0;
  logic [7:0] wr_prev_a = 8'h00, wr_last_a = 8'h00;
  logic [7:0] res_min = 8'hEE, res_max = 8'hEE;

  always @(posedge clk) begin
    if (dm_wr_en) begin
      wr_cnt    <= wr_cnt + 1;
      wr_prev_a <= wr_last_a;
      wr_last_a <= dm_addr;
      if (dm_addr == 8'd64) res_min <= dm_wr_data;
      else if (dm_addr == 8'd65) res_max <= dm_wr_data;
    end
  end

  typedef struct {
    int kind;   // 0 all A5A5, 1 single FFFF, 2 one-hot, 3 random
    int seed;
    int e_min, e_mna, e_mnb;
    int e_max, e_mxa, e_mxb;
  } vec_t;

  vec_t vecs[13];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_words(input int kind, input int seed);
    logic [31:0] s;
    s = 32'(seed);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: words[i] = 16'hA5A5;
        1: words[i] = (i == 1) ? 16'hFFFF : 16'h0000;
        2: words[i] = 16'(1 << (i % 16));
        default: begin
          s = s * 32'd1103515245 + 32'd12345;
          words[i] = s[30:15];
        end
      endcase
      op_mem[2 * i]     = words[i][15:8];
      op_mem[2 * i + 1] = words[i][7:0];
    end
  endtask

  // Independent golden model of the full pair scan.
  task automatic model(inout vec_t v);
    int d;
    v.e_min = 16; v.e_mna = 0; v.e_mnb = 0;
    v.e_max = 0;  v.e_mxa = 0; v.e_mxb = 0;
    for (int j = 0; j < N - 1; j++) begin
      for (int k = j + 1; k < N; k++) begin
        d = $countones(words[j] ^ words[k]);
        if (d < v.e_min) begin v.e_min = d; v.e_mna = j; v.e_mnb = k; end
        if (d > v.e_max) begin v.e_max = d; v.e_mxa = j; v.e_mxb = k; end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_min"}, min_dist, 16);
    check({tag, "_max"}, max_dist, 0);
    check({tag, "_idx"}, {min_idx_a, min_idx_b, max_idx_a, max_idx_b}, 0);
    check({tag, "_wren"}, dm_wr_en, 0);
    check({tag, "_addr"}, dm_addr, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
  endtask

  // Release reset at the current negedge and count edges until done.
  task automatic run_to_done(output int edges);
    reset = 1'b0;
    edges = 0;
    while (edges < 3000) begin
      @(posedge clk);
      edges++;
      #1;
      if (done) break;
    end
    check("done_edge", edges, LAT);
  endtask

  task automatic check_results(input vec_t v, input int base);
    check("mem64", res_min, v.e_min);
    check("mem65", res_max, v.e_max);
    check("min_dist", min_dist, v.e_min);
    check("max_dist", max_dist, v.e_max);
    check("min_idx_a", min_idx_a, v.e_mna);
    check("min_idx_b", min_idx_b, v.e_mnb);
    check("max_idx_a", max_idx_a, v.e_mxa);
    check("max_idx_b", max_idx_b, v.e_mxb);
    check("wr_count", wr_cnt - base, 2);
    check("wr_addr_first", wr_prev_a, 64);
    check("wr_addr_second", wr_last_a, 65);
  endtask

  initial begin
    int   edges, base, bad;
    vec_t v;
    logic [7:0] keep_min, keep_max;

    vecs[0] = '{0, 0, 0, 0, 1, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 2, 16, 0, 1};
    vecs[2] = '{2, 0, 0, 0, 16, 2, 0, 1};
    for (int i = 3; i < 13; i++) vecs[i] = '{3, 1000 + 77 * i, -1, -1, -1, -1, -1, -1};

    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      do_reset();
      fill_words(v.kind, v.seed);
      if (v.kind == 3) model(v);
      base = wr_cnt;
      run_to_done(edges);
      check_results(v, base);
    end

    // Hold after done: no further writes, done stays high, results stable.
    base = wr_cnt;
    keep_min = res_min;
    keep_max = res_max;
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (!done || dm_wr_en) bad++;
    end
    check("hold_bad_cycles", bad, 0);
    check("hold_writes", wr_cnt - base, 0);
    check("hold_mem64", res_min, keep_min);
    check("hold_mem65", res_max, keep_max);

    // Abort at edge 700, then full rerun from scratch.
    v = '{3, 4242, -1, -1, -1, -1, -1, -1};
    do_reset();
    fill_words(v.kind, v.seed);
    model(v);
    base = wr_cnt;
    reset = 1'b0;
    repeat (699) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    check("abort_writes", wr_cnt - base, 0);
    @(negedge clk);
    run_to_done(edges);
    check_results(v, base);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
